// File: rtl/clk_div_monitor.sv
// clk_div_monitor: samples a divided clock in the clock_in domain, measures period and
// high time per rising edge, tracks lock and counts errors.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 3,
    parameter int HI_MIN     = 1,
    parameter int HI_MAX     = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             div_clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

    state_t            state, state_next;
    logic [GOOD_W-1:0] good_cnt, good_cnt_next;
    logic [1:0]        sync_pipe;
    logic              sync, prev, rise;
    logic [CNT_W-1:0]  per, hi;
    logic              good, timeout;
    logic              load, err_next, valid_next;

    // Two-flop synchronizer followed by a previous-sample register for edge detect.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_pipe <= '0;
            prev      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], div_clk_in};
            prev      <= sync;
        end
    end

    assign sync = sync_pipe[1];
    assign rise = sync & ~prev;

    // On the rise cycle per/hi still hold the just-finished period's measurements.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            per <= '0;
            hi  <= '0;
        end else if (rise) begin
            per <= CNT_W'(1);
            hi  <= CNT_W'(1);
        end else begin
            if (per != CNT_MAX)
                per <= per + CNT_W'(1);
            if (sync && (hi != CNT_MAX))
                hi <= hi + CNT_W'(1);
        end
    end

    assign good    = (per == CNT_W'(EXP_PERIOD)) &&
                     (hi >= CNT_W'(HI_MIN)) && (hi <= CNT_W'(HI_MAX));
    assign timeout = (per == CNT_W'(TIMEOUT)) && !rise;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state    <= SEEK;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        load          = 1'b0;
        err_next      = 1'b0;
        valid_next    = 1'b0;
        case (state)
            SEEK: begin
                if (rise) begin
                    state_next    = ACQUIRE;
                    good_cnt_next = '0;
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    load       = 1'b1;
                    valid_next = 1'b1;
                    if (good) begin
                        good_cnt_next = good_cnt + GOOD_W'(1);
                        if (good_cnt == GOOD_W'(LOCK_COUNT - 1))
                            state_next = LOCKED;
                    end else begin
                        err_next      = 1'b1;
                        good_cnt_next = '0;
                    end
                end else if (timeout) begin
                    err_next      = 1'b1;
                    good_cnt_next = '0;
                    state_next    = SEEK;
                end
            end
            LOCKED: begin
                if (rise) begin
                    load       = 1'b1;
                    valid_next = 1'b1;
                    if (!good) begin
                        err_next      = 1'b1;
                        good_cnt_next = '0;
                        state_next    = ACQUIRE;
                    end
                end else if (timeout) begin
                    err_next      = 1'b1;
                    good_cnt_next = '0;
                    state_next    = SEEK;
                end
            end
            default: begin
                state_next    = SEEK;
                good_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            err          <= 1'b0;
            err_count    <= '0;
        end else begin
            period_valid <= valid_next;
            err          <= err_next;
            if (load) begin
                period_out <= per;
                high_out   <= hi;
            end
            if (err_next && (err_count != CNT_MAX))
                err_count <= err_count + CNT_W'(1);
        end
    end

    // Derived straight from the state register so it drops in the same cycle as err.
    assign locked = (state == LOCKED);

endmodule
